// File: rtl/gfx_pkg.sv
// Shared graphics types: layer configuration record, 4:4:4 pixel, compositor defaults.
package gfx_pkg;

  // Config fields are stored at these maximum widths and zero-extended from the port widths.
  localparam int unsigned GFX_COORD_MAX = 16;
  localparam int unsigned GFX_ADDR_MAX  = 32;

  localparam int unsigned GFX_MARK_THRESH = 5;
  localparam logic [11:0] GFX_BG_COLOR    = 12'hfff;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic                     en;
    logic                     opaque;
    logic [GFX_COORD_MAX-1:0] x;
    logic [GFX_COORD_MAX-1:0] y;
    logic [GFX_COORD_MAX-1:0] w;
    logic [GFX_COORD_MAX-1:0] h;
    logic [GFX_ADDR_MAX-1:0]  base;
  } layer_cfg_t;

endpackage

// File: rtl/sprite_layer_hit.sv
// Per-layer rectangle hit test and image-memory address for one pixel request.
module sprite_layer_hit
  import gfx_pkg::*;
#(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned ADDR_W  = 18
) (
  input  layer_cfg_t          cfg_i,
  input  logic [COORD_W-1:0]  x_i,
  input  logic [COORD_W-1:0]  y_i,
  output logic                hit_o,
  output logic [ADDR_W-1:0]   addr_o
);

  // One extra bit so x+w / y+h never wrap past the screen edge.
  localparam int unsigned EW = GFX_COORD_MAX + 1;

  logic [EW-1:0] xr, yr, dx, dy;
  logic          in_x, in_y;

  always_comb begin
    xr     = EW'(x_i);
    yr     = EW'(y_i);
    dx     = xr - EW'(cfg_i.x);
    dy     = yr - EW'(cfg_i.y);
    in_x   = (xr >= EW'(cfg_i.x)) && (xr < EW'(cfg_i.x) + EW'(cfg_i.w));
    in_y   = (yr >= EW'(cfg_i.y)) && (yr < EW'(cfg_i.y) + EW'(cfg_i.h));
    hit_o  = cfg_i.en && in_x && in_y;
    addr_o = ADDR_W'(cfg_i.base + GFX_ADDR_MAX'(dy) * GFX_ADDR_MAX'(cfg_i.w) + GFX_ADDR_MAX'(dx));
  end

endmodule

// File: rtl/sprite_compositor.sv
// Multi-layer sprite compositor: double-buffered layer config, 3-stage pixel pipeline
// (S0 hit/address, S1 ROM read, S2 priority select), highest visible layer wins.
module sprite_compositor
  import gfx_pkg::*;
#(
  parameter int unsigned      NUM_LAYERS  = 4,
  parameter int unsigned      COORD_W     = 10,
  parameter int unsigned      ADDR_W      = 18,
  parameter int unsigned      PIX_W       = 12,
  parameter int unsigned      MARK_THRESH = GFX_MARK_THRESH,
  parameter logic [PIX_W-1:0] BG_COLOR    = GFX_BG_COLOR,
  localparam int unsigned     LW          = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_frame_start,
  input  logic                         i_cfg_we,
  input  logic [LW-1:0]                i_cfg_layer,
  input  logic [COORD_W-1:0]           i_cfg_x,
  input  logic [COORD_W-1:0]           i_cfg_y,
  input  logic [COORD_W-1:0]           i_cfg_w,
  input  logic [COORD_W-1:0]           i_cfg_h,
  input  logic [ADDR_W-1:0]            i_cfg_base,
  input  logic                         i_cfg_en,
  input  logic                         i_cfg_opaque,
  input  logic                         i_valid,
  input  logic [COORD_W-1:0]           i_x_read,
  input  logic [COORD_W-1:0]           i_y_read,
  output logic [NUM_LAYERS-1:0]        o_ren,
  output logic [NUM_LAYERS*ADDR_W-1:0] o_addr,
  input  logic [NUM_LAYERS*PIX_W-1:0]  i_pix,
  input  logic [NUM_LAYERS*4-1:0]      i_mark,
  output logic                         o_valid,
  output logic [3:0]                   o_r,
  output logic [3:0]                   o_g,
  output logic [3:0]                   o_b
);

  layer_cfg_t pend_q [NUM_LAYERS];
  layer_cfg_t pend_d [NUM_LAYERS];
  layer_cfg_t act_q  [NUM_LAYERS];
  layer_cfg_t act_d  [NUM_LAYERS];
  layer_cfg_t wr_cfg;

  logic [NUM_LAYERS-1:0]        hit_s0;
  logic [ADDR_W-1:0]            addr_s0 [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]        ren_q, opq0_q, hit1_q, opq1_q;
  logic [NUM_LAYERS*ADDR_W-1:0] addr_q;
  logic                         v0_q, v1_q, valid_q;
  rgb444_t                      rgb_q, rgb_d;

  always_comb begin
    wr_cfg        = '0;
    wr_cfg.en     = i_cfg_en;
    wr_cfg.opaque = i_cfg_opaque;
    wr_cfg.x      = GFX_COORD_MAX'(i_cfg_x);
    wr_cfg.y      = GFX_COORD_MAX'(i_cfg_y);
    wr_cfg.w      = GFX_COORD_MAX'(i_cfg_w);
    wr_cfg.h      = GFX_COORD_MAX'(i_cfg_h);
    wr_cfg.base   = GFX_ADDR_MAX'(i_cfg_base);
  end

  // Commit copies the post-write pending set, so a coincident write reaches active.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      pend_d[i] = pend_q[i];
      if (i_cfg_we && (32'(i_cfg_layer) == i)) pend_d[i] = wr_cfg;
      act_d[i] = i_frame_start ? pend_d[i] : act_q[i];
    end
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    sprite_layer_hit #(
      .COORD_W (COORD_W),
      .ADDR_W  (ADDR_W)
    ) u_hit (
      .cfg_i  (act_q[g]),
      .x_i    (i_x_read),
      .y_i    (i_y_read),
      .hit_o  (hit_s0[g]),
      .addr_o (addr_s0[g])
    );
  end

  always_comb begin
    rgb_d = rgb444_t'(BG_COLOR);
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (hit1_q[i] && (opq1_q[i] || (32'(i_mark[4*i +: 4]) > MARK_THRESH)))
        rgb_d = rgb444_t'(i_pix[PIX_W*i +: PIX_W]);
    end
  end

  // Opaque is captured with the hit so in-flight pixels ignore later commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
      ren_q   <= '0;
      addr_q  <= '0;
      opq0_q  <= '0;
      hit1_q  <= '0;
      opq1_q  <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      valid_q <= 1'b0;
      rgb_q   <= rgb444_t'(BG_COLOR);
    end else begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        pend_q[i]                  <= pend_d[i];
        act_q[i]                   <= act_d[i];
        ren_q[i]                   <= i_valid && hit_s0[i];
        addr_q[ADDR_W*i +: ADDR_W] <= (i_valid && hit_s0[i]) ? addr_s0[i] : '0;
        opq0_q[i]                  <= act_q[i].opaque;
      end
      v0_q    <= i_valid;
      v1_q    <= v0_q;
      hit1_q  <= ren_q;
      opq1_q  <= opq0_q;
      valid_q <= v1_q;
      if (v1_q) rgb_q <= rgb_d;
    end
  end

  assign o_ren   = ren_q;
  assign o_addr  = addr_q;
  assign o_valid = valid_q;
  assign o_r     = rgb_q.r;
  assign o_g     = rgb_q.g;
  assign o_b     = rgb_q.b;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor with a synchronous ROM model and a rule-level reference.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_frame_start, i_cfg_we, i_cfg_en, i_cfg_opaque, i_valid;
  logic [1:0]  i_cfg_layer;
  logic [9:0]  i_cfg_x, i_cfg_y, i_cfg_w, i_cfg_h, i_x_read, i_y_read;
  logic [17:0] i_cfg_base;
  logic [3:0]  o_ren;
  logic [71:0] o_addr;
  logic [47:0] i_pix = '0;
  logic [15:0] i_mark = '0;
  logic        o_valid;
  logic [3:0]  o_r, o_g, o_b;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sprite_compositor #(
    .NUM_LAYERS  (4),
    .COORD_W     (10),
    .ADDR_W      (18),
    .PIX_W       (12),
    .MARK_THRESH (5),
    .BG_COLOR    (12'hfff)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_frame_start (i_frame_start),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_layer   (i_cfg_layer),
    .i_cfg_x       (i_cfg_x),
    .i_cfg_y       (i_cfg_y),
    .i_cfg_w       (i_cfg_w),
    .i_cfg_h       (i_cfg_h),
    .i_cfg_base    (i_cfg_base),
    .i_cfg_en      (i_cfg_en),
    .i_cfg_opaque  (i_cfg_opaque),
    .i_valid       (i_valid),
    .i_x_read      (i_x_read),
    .i_y_read      (i_y_read),
    .o_ren         (o_ren),
    .o_addr        (o_addr),
    .i_pix         (i_pix),
    .i_mark        (i_mark),
    .o_valid       (o_valid),
    .o_r           (o_r),
    .o_g           (o_g),
    .o_b           (o_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int x, y, w, h, base;
    bit en, opq;
  } mcfg_t;

  mcfg_t       m_pend [4];
  mcfg_t       m_act  [4];
  bit          ovr      [4];
  logic [11:0] ovr_pix  [4];
  logic [3:0]  ovr_mark [4];
  logic        hist_v   [400];
  logic [11:0] hist_rgb [400];

  function automatic logic [11:0] rom_pix(input int l, input int a);
    if (ovr[l]) return ovr_pix[l];
    return 12'((a * 37 + l * 1013) ^ (a >> 5));
  endfunction

  function automatic logic [3:0] rom_mark(input int l, input int a);
    if (ovr[l]) return ovr_mark[l];
    return 4'((a >> 2) + l * 5);
  endfunction

  // Synchronous ROM: data appears one cycle after a read enable.
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (o_ren[l]) begin
        i_pix[l*12 +: 12] <= rom_pix(l, int'(o_addr[l*18 +: 18]));
        i_mark[l*4 +: 4]  <= rom_mark(l, int'(o_addr[l*18 +: 18]));
      end
    end
  end

  function automatic void model_pixel(input int x, input int y, output logic [3:0] ren,
                                      output logic [71:0] addr, output logic [11:0] rgb);
    ren  = '0;
    addr = '0;
    rgb  = 12'hfff;
    for (int l = 0; l < 4; l++) begin
      mcfg_t c;
      int a;
      c = m_act[l];
      if (c.en && x >= c.x && x < c.x + c.w && y >= c.y && y < c.y + c.h) begin
        a = (c.base + (y - c.y) * c.w + (x - c.x)) % 262144;
        ren[l] = 1'b1;
        addr[l*18 +: 18] = 18'(a);
        if (c.opq || rom_mark(l, a) > 5) rgb = rom_pix(l, a);
      end
    end
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < 4; l++) begin
      m_pend[l] = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
      m_act[l]  = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cfg_write(input bit we, input int layer, input int x, input int y, input int w,
                           input int h, input int base, input bit en, input bit opq, input bit fs);
    i_cfg_we = we; i_cfg_layer = 2'(layer);
    i_cfg_x = 10'(x); i_cfg_y = 10'(y); i_cfg_w = 10'(w); i_cfg_h = 10'(h);
    i_cfg_base = 18'(base); i_cfg_en = en; i_cfg_opaque = opq; i_frame_start = fs;
    @(posedge clk);
    if (we && layer < 4) m_pend[layer] = '{x, y, w, h, base, en, opq};
    if (fs) for (int l = 0; l < 4; l++) m_act[l] = m_pend[l];
    #1;
    i_cfg_we = 1'b0; i_frame_start = 1'b0;
  endtask

  task automatic run_pixel(input int x, input int y, output logic [3:0] ren, output logic [71:0] addr,
                           output logic v2, output logic v3, output logic [11:0] rgb);
    i_valid = 1'b1; i_x_read = 10'(x); i_y_read = 10'(y);
    @(posedge clk); #1;
    ren = o_ren; addr = o_addr; i_valid = 1'b0;
    @(posedge clk); #1;
    v2 = o_valid;
    @(posedge clk); #1;
    v3 = o_valid; rgb = {o_r, o_g, o_b};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] ren, mr; logic [71:0] addr, ma; logic v2, v3; logic [11:0] rgb, mg;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_ren, o_addr, o_r, o_g, o_b} !== {1'b0, 4'h0, 72'h0, 12'hfff}) begin
      fails++;
      $display("FAIL reset_state: got valid=%b ren=%b addr=%h rgb=%h%h%h want 0/0/0/fff",
               o_valid, o_ren, o_addr, o_r, o_g, o_b);
    end
    rst = 1'b0;
    model_reset();
    model_pixel(0, 0, mr, ma, mg);
    run_pixel(0, 0, ren, addr, v2, v3, rgb);
    checks++;
    if ({v2, v3, ren, rgb} !== {1'b0, 1'b1, 4'h0, 12'hfff}) begin
      fails++;
      $display("FAIL reset_first_pixel: got v2=%b v3=%b ren=%b rgb=%h want 0 1 0000 fff", v2, v3, ren, rgb);
    end
  endtask

  task automatic test_addr();
    logic [3:0] ren, mr; logic [71:0] addr, ma; logic v2, v3; logic [11:0] rgb, mg;
    int px [4] = '{110, 280, 279, 99};
    int py [4] = '{60, 60, 229, 50};
    ovr[0] = 1'b1; ovr_pix[0] = 12'h0f0; ovr_mark[0] = 4'hf;
    cfg_write(1'b1, 0, 100, 50, 180, 180, 0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      model_pixel(px[k], py[k], mr, ma, mg);
      run_pixel(px[k], py[k], ren, addr, v2, v3, rgb);
      checks++;
      if ({v2, v3, ren, addr, rgb} !== {1'b0, 1'b1, mr, ma, mg}) begin
        fails++;
        $display("FAIL addr_pixel%0d: got v=%b%b ren=%b addr=%h rgb=%h want v=01 ren=%b addr=%h rgb=%h",
                 k, v2, v3, ren, addr, rgb, mr, ma, mg);
      end
      if (k == 0) begin
        checks++;
        if (addr[17:0] !== 18'd1810) begin
          fails++;
          $display("FAIL addr_1810: got %0d want 1810", addr[17:0]);
        end
      end
      if (k == 1) begin
        checks++;
        if ({ren, rgb} !== {4'h0, 12'hfff}) begin
          fails++;
          $display("FAIL addr_right_edge_miss: got ren=%b rgb=%h want 0000 fff", ren, rgb);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] ren, mr; logic [71:0] addr, ma; logic v2, v3; logic [11:0] rgb, mg;
    logic [3:0]  mk   [4] = '{4'hf, 4'h5, 4'h6, 4'h5};
    logic [11:0] want [4] = '{12'hf00, 12'h0f0, 12'hf00, 12'hf00};
    ovr[1] = 1'b1; ovr_pix[1] = 12'hf00;
    cfg_write(1'b1, 1, 105, 55, 20, 20, 500, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ovr_mark[1] = mk[k];
      if (k == 3) cfg_write(1'b1, 1, 105, 55, 20, 20, 500, 1'b1, 1'b1, 1'b1);
      model_pixel(110, 60, mr, ma, mg);
      run_pixel(110, 60, ren, addr, v2, v3, rgb);
      checks++;
      if ({v2, v3, ren, addr, rgb} !== {1'b0, 1'b1, mr, ma, mg}) begin
        fails++;
        $display("FAIL prio_model%0d: got v=%b%b ren=%b addr=%h rgb=%h want ren=%b addr=%h rgb=%h",
                 k, v2, v3, ren, addr, rgb, mr, ma, mg);
      end
      checks++;
      if (rgb !== want[k]) begin
        fails++;
        $display("FAIL prio_rgb%0d: got %h want %h", k, rgb, want[k]);
      end
    end
  endtask

  task automatic test_commit();
    logic [3:0] ren; logic [71:0] addr; logic v2, v3; logic [11:0] rgb;
    ovr[2] = 1'b1; ovr_pix[2] = 12'h00f; ovr_mark[2] = 4'hf;
    ovr[3] = 1'b1; ovr_pix[3] = 12'h0ff; ovr_mark[3] = 4'h0;
    cfg_write(1'b1, 2, 300, 300, 10, 10, 100, 1'b1, 1'b0, 1'b0);
    run_pixel(305, 305, ren, addr, v2, v3, rgb);
    checks++;
    if ({v3, ren, rgb} !== {1'b1, 4'h0, 12'hfff}) begin
      fails++;
      $display("FAIL commit_pending_only: got v=%b ren=%b rgb=%h want 1 0000 fff", v3, ren, rgb);
    end
    cfg_write(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    run_pixel(305, 305, ren, addr, v2, v3, rgb);
    checks++;
    if ({v3, ren, addr[2*18 +: 18], rgb} !== {1'b1, 4'b0100, 18'd155, 12'h00f}) begin
      fails++;
      $display("FAIL commit_pulse: got v=%b ren=%b addr2=%0d rgb=%h want 1 0100 155 00f",
               v3, ren, addr[2*18 +: 18], rgb);
    end
    cfg_write(1'b1, 2, 300, 300, 10, 10, 100, 1'b0, 1'b0, 1'b1);
    run_pixel(305, 305, ren, addr, v2, v3, rgb);
    checks++;
    if ({ren, rgb} !== {4'h0, 12'hfff}) begin
      fails++;
      $display("FAIL commit_writethrough_disable: got ren=%b rgb=%h want 0000 fff", ren, rgb);
    end
    cfg_write(1'b1, 3, 400, 400, 5, 5, 0, 1'b1, 1'b1, 1'b1);
    run_pixel(402, 402, ren, addr, v2, v3, rgb);
    checks++;
    if ({ren, addr[3*18 +: 18], rgb} !== {4'b1000, 18'd12, 12'h0ff}) begin
      fails++;
      $display("FAIL commit_writethrough_enable: got ren=%b addr3=%0d rgb=%h want 1000 12 0ff",
               ren, addr[3*18 +: 18], rgb);
    end
  endtask

  task automatic test_nowrap();
    logic [3:0] ren; logic [71:0] addr; logic v2, v3; logic [11:0] rgb;
    cfg_write(1'b1, 3, 1000, 0, 100, 1000, 0, 1'b1, 1'b1, 1'b1);
    run_pixel(5, 10, ren, addr, v2, v3, rgb);
    checks++;
    if ({v3, ren, addr, rgb} !== {1'b1, 4'h0, 72'h0, 12'hfff}) begin
      fails++;
      $display("FAIL nowrap_miss: got v=%b ren=%b addr=%h rgb=%h want 1 0000 0 fff", v3, ren, addr, rgb);
    end
    run_pixel(1010, 10, ren, addr, v2, v3, rgb);
    checks++;
    if ({ren, addr[3*18 +: 18], rgb} !== {4'b1000, 18'd1010, 12'h0ff}) begin
      fails++;
      $display("FAIL nowrap_hit: got ren=%b addr3=%0d rgb=%h want 1000 1010 0ff", ren, addr[3*18 +: 18], rgb);
    end
    cfg_write(1'b1, 2, 500, 500, 0, 10, 0, 1'b1, 1'b1, 1'b1);
    run_pixel(500, 500, ren, addr, v2, v3, rgb);
    checks++;
    if ({ren, rgb} !== {4'h0, 12'hfff}) begin
      fails++;
      $display("FAIL zero_size: got ren=%b rgb=%h want 0000 fff", ren, rgb);
    end
  endtask

  task automatic test_random();
    bit have_last = 1'b0;
    logic [11:0] last_rgb = 12'hfff;
    for (int l = 0; l < 4; l++) ovr[l] = 1'b0;
    for (int l = 0; l < 4; l++)
      cfg_write(1'b1, l, int'($urandom_range(0, 800)), int'($urandom_range(0, 800)),
                int'($urandom_range(1, 300)), int'($urandom_range(1, 300)),
                int'($urandom_range(0, 262143)), 1'b1, bit'($urandom_range(0, 1)), l == 3);
    for (int c = 0; c < 400; c++) begin
      logic [3:0] mr; logic [71:0] ma; logic [11:0] mg;
      bit v, we, fs; int x, y, l;
      v = ($urandom_range(0, 9) < 7);
      l = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1 && m_act[l].w > 0 && m_act[l].h > 0) begin
        x = (m_act[l].x + int'($urandom_range(0, m_act[l].w))) % 1024;
        y = (m_act[l].y + int'($urandom_range(0, m_act[l].h))) % 1024;
      end else begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end
      if (v) model_pixel(x, y, mr, ma, mg);
      else begin mr = '0; ma = '0; mg = '0; end
      hist_v[c] = v; hist_rgb[c] = mg;
      i_valid = v; i_x_read = 10'(x); i_y_read = 10'(y);
      we = ($urandom_range(0, 7) == 0);
      fs = ($urandom_range(0, 5) == 0);
      begin
        int cl, cx, cy, cw, ch, cb; bit ce, co;
        cl = int'($urandom_range(0, 3));
        cx = int'($urandom_range(0, 1023)); cy = int'($urandom_range(0, 1023));
        cw = int'($urandom_range(0, 400));  ch = int'($urandom_range(0, 400));
        cb = int'($urandom_range(0, 262143));
        ce = ($urandom_range(0, 4) != 0); co = bit'($urandom_range(0, 1));
        i_cfg_we = we; i_cfg_layer = 2'(cl); i_cfg_x = 10'(cx); i_cfg_y = 10'(cy);
        i_cfg_w = 10'(cw); i_cfg_h = 10'(ch); i_cfg_base = 18'(cb); i_cfg_en = ce;
        i_cfg_opaque = co; i_frame_start = fs;
        @(posedge clk);
        if (we) m_pend[cl] = '{cx, cy, cw, ch, cb, ce, co};
        if (fs) for (int k = 0; k < 4; k++) m_act[k] = m_pend[k];
      end
      #1;
      i_cfg_we = 1'b0; i_frame_start = 1'b0;
      checks++;
      if ({o_ren, o_addr} !== {mr, ma}) begin
        fails++;
        $display("FAIL rand_s0 c=%0d: got ren=%b addr=%h want ren=%b addr=%h", c, o_ren, o_addr, mr, ma);
      end
      checks++;
      if (o_valid !== ((c >= 2) ? hist_v[c-2] : 1'b0)) begin
        fails++;
        $display("FAIL rand_valid c=%0d: got %b want %b", c, o_valid, (c >= 2) ? hist_v[c-2] : 1'b0);
      end
      if (c >= 2 && hist_v[c-2]) begin
        checks++;
        if ({o_r, o_g, o_b} !== hist_rgb[c-2]) begin
          fails++;
          $display("FAIL rand_rgb c=%0d: got %h%h%h want %h", c, o_r, o_g, o_b, hist_rgb[c-2]);
        end
        last_rgb = hist_rgb[c-2];
        have_last = 1'b1;
      end else if (have_last) begin
        checks++;
        if ({o_r, o_g, o_b} !== last_rgb) begin
          fails++;
          $display("FAIL rand_hold c=%0d: got %h%h%h want %h", c, o_r, o_g, o_b, last_rgb);
        end
      end
    end
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_inflight();
    logic [3:0] ren; logic [71:0] addr; logic v2, v3; logic [11:0] rgb;
    int bad_valid = 0;
    ovr[0] = 1'b1; ovr_pix[0] = 12'h123; ovr_mark[0] = 4'hf;
    cfg_write(1'b1, 0, 0, 0, 500, 500, 0, 1'b1, 1'b1, 1'b1);
    i_valid = 1'b1; i_x_read = 10'd10; i_y_read = 10'd10;
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1; i_valid = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_ren, o_addr, o_r, o_g, o_b} !== {1'b0, 4'h0, 72'h0, 12'hfff}) begin
      fails++;
      $display("FAIL rst_inflight_now: got valid=%b ren=%b addr=%h rgb=%h%h%h want 0/0/0/fff",
               o_valid, o_ren, o_addr, o_r, o_g, o_b);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0) bad_valid++;
    end
    checks++;
    if (bad_valid != 0) begin
      fails++;
      $display("FAIL rst_no_stale_valid: got %0d valid cycles want 0", bad_valid);
    end
    cfg_write(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    run_pixel(10, 10, ren, addr, v2, v3, rgb);
    checks++;
    if ({v2, v3, ren, addr, rgb} !== {1'b0, 1'b1, 4'h0, 72'h0, 12'hfff}) begin
      fails++;
      $display("FAIL rst_layers_disabled: got v=%b%b ren=%b addr=%h rgb=%h want 01 0000 0 fff",
               v2, v3, ren, addr, rgb);
    end
  endtask

  initial begin
    i_frame_start = 1'b0; i_cfg_we = 1'b0; i_cfg_layer = '0;
    i_cfg_x = '0; i_cfg_y = '0; i_cfg_w = '0; i_cfg_h = '0; i_cfg_base = '0;
    i_cfg_en = 1'b0; i_cfg_opaque = 1'b0; i_valid = 1'b0; i_x_read = '0; i_y_read = '0;
    for (int l = 0; l < 4; l++) begin ovr[l] = 1'b0; ovr_pix[l] = '0; ovr_mark[l] = '0; end
    model_reset();
    test_reset();
    test_addr();
    test_priority();
    test_commit();
    test_nowrap();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
